// File: rtl/keccak_theta_iter.sv
// Iterative, handshaked Keccak theta step for a 5x5 state of LANE_W-bit lanes.
// Optional macro KECCAK_THETA_PARITY_OUT_EN exposes the column parities C[x] as parity_out.
module keccak_theta_iter #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  state_out,
  output logic                  busy
`ifdef KECCAK_THETA_PARITY_OUT_EN
  , output logic [5*LANE_W-1:0] parity_out
`endif
);

  localparam int SW = 25 * LANE_W;

  typedef enum logic [1:0] {IDLE, PARITY, APPLY, DONE} st_e;

  st_e                     state_q, state_d;
  logic [SW-1:0]           a_q, out_q, theta;
  logic [4:0][LANE_W-1:0]  c_q, d;
  logic [2:0]              col_q;
  logic [LANE_W-1:0]       col_par;
  logic                    accept;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = out_q;

`ifdef KECCAK_THETA_PARITY_OUT_EN
  assign parity_out = c_q;
`endif

  // Parity of the column currently selected by col_q; 5..7 yield zero.
  always_comb begin
    col_par = '0;
    for (int x = 0; x < 5; x++) begin
      if (col_q == 3'(x)) begin
        for (int y = 0; y < 5; y++) col_par ^= a_q[(5*x+y)*LANE_W +: LANE_W];
      end
    end
  end

  for (genvar x = 0; x < 5; x++) begin : g_col
    assign d[x] = c_q[(x+4)%5] ^ {c_q[(x+1)%5][LANE_W-2:0], c_q[(x+1)%5][LANE_W-1]};
    for (genvar y = 0; y < 5; y++) begin : g_lane
      assign theta[(5*x+y)*LANE_W +: LANE_W] = a_q[(5*x+y)*LANE_W +: LANE_W] ^ d[x];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = PARITY;
      PARITY:  if (col_q == 3'd4) state_d = APPLY;
      APPLY:                      state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      c_q     <= '0;
      col_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= state_in;
        c_q   <= '0;
        col_q <= '0;
      end
      if (state_q == PARITY) begin
        for (int x = 0; x < 5; x++) begin
          if (col_q == 3'(x)) c_q[x] <= col_par;
        end
        col_q <= col_q + 3'd1;
      end
      // Result register is only rewritten here, so it survives the output handshake.
      if (state_q == APPLY) out_q <= theta;
    end
  end

endmodule

// File: tb/tb_keccak_theta_iter.sv
// Self-checking bench for keccak_theta_iter: LANE_W=64 and LANE_W=8 instances vs a lane-level model.
module tb_keccak_theta_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic iv64 = 1'b0, or64 = 1'b0, ir64, ov64, bz64;
  logic [1599:0] si64 = '0, so64;
  logic iv8 = 1'b0, or8 = 1'b0, ir8, ov8, bz8;
  logic [199:0] si8 = '0, so8;
`ifdef KECCAK_THETA_PARITY_OUT_EN
  logic [319:0] po64;
  logic [39:0]  po8;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keccak_theta_iter #(.LANE_W(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .state_in(si64),
    .out_valid(ov64), .out_ready(or64), .state_out(so64), .busy(bz64)
`ifdef KECCAK_THETA_PARITY_OUT_EN
    , .parity_out(po64)
`endif
  );

  keccak_theta_iter #(.LANE_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .state_in(si8),
    .out_valid(ov8), .out_ready(or8), .state_out(so8), .busy(bz8)
`ifdef KECCAK_THETA_PARITY_OUT_EN
    , .parity_out(po8)
`endif
  );

  function automatic logic [63:0] getl(input logic [1599:0] a, input int x, input int y, input int w);
    logic [1599:0] t;
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    t = a >> ((5*x+y)*w);
    return t[63:0] & m;
  endfunction

  function automatic logic [319:0] par_model(input logic [1599:0] a, input int w);
    logic [319:0] r;
    logic [63:0] c;
    r = '0;
    for (int x = 0; x < 5; x++) begin
      c = '0;
      for (int y = 0; y < 5; y++) c ^= getl(a, x, y, w);
      r |= 320'(c) << (x*w);
    end
    return r;
  endfunction

  function automatic logic [1599:0] theta_model(input logic [1599:0] a, input int w);
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] m, rot;
    logic [1599:0] r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = '0;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] ^= getl(a, x, y, w);
    end
    for (int x = 0; x < 5; x++) begin
      rot  = ((c[(x+1)%5] << 1) | (c[(x+1)%5] >> (w-1))) & m;
      d[x] = c[(x+4)%5] ^ rot;
    end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r |= 1600'(getl(a, x, y, w) ^ d[x]) << ((5*x+y)*w);
    return r;
  endfunction

  function automatic logic [1599:0] rnd_state();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    int idx;
    idx = 0;
    for (int i = 24; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s chunk%0d observed=%h expected=%h", tag, idx, obs[idx*64 +: 64], exp[idx*64 +: 64]);
    end
  endtask

  // One full transaction on the selected instance, holding DONE for `stall` cycles.
  task automatic xact(input bit w8, input logic [1599:0] a, input logic [1599:0] exp,
                      input int stall, input string tag);
    int n, lat, bad;
    logic [1599:0] obs;
    n = 0;
    while (!(w8 ? ir8 : ir64) && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready"}, 1600'(w8 ? ir8 : ir64), 1600'(1));
    if (w8) si8 = a[199:0]; else si64 = a;
    if (w8) iv8 = 1'b1; else iv64 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; iv64 = 1'b0;
    chk({tag, "_busy"}, 1600'(w8 ? bz8 : bz64), 1600'(1));
    lat = 0;
    while (!(w8 ? ov8 : ov64) && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, 1600'(lat), 1600'(6));
    obs = w8 ? 1600'(so8) : so64;
    chk({tag, "_data"}, obs, exp);
`ifdef KECCAK_THETA_PARITY_OUT_EN
    chk({tag, "_parity"}, w8 ? 1600'(po8) : 1600'(po64), 1600'(par_model(a, w8 ? 8 : 64)));
`endif
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      obs = w8 ? 1600'(so8) : so64;
      if (!(w8 ? ov8 : ov64) || (w8 ? ir8 : ir64) || obs !== exp) bad++;
    end
    if (stall > 0) chk({tag, "_stall"}, 1600'(bad), 1600'(0));
    if (w8) or8 = 1'b1; else or64 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; or64 = 1'b0;
    obs = w8 ? 1600'(so8) : so64;
    chk({tag, "_hs"}, {1598'(0), (w8 ? ov8 : ov64), (w8 ? ir8 : ir64)}, 1600'(1));
    chk({tag, "_hold"}, obs, exp);
  endtask

  initial begin
    logic [1599:0] a, e;
    int bad;

    // Reset state
    #12;
    chk("rst_ready64", 1600'(ir64), 1600'(0));
    chk("rst_ready8", 1600'(ir8), 1600'(0));
    chk("rst_valid", 1600'({ov64, ov8}), 1600'(0));
    chk("rst_busy", 1600'({bz64, bz8}), 1600'(0));
    chk("rst_out", so64, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", 1600'({ir64, ir8}), 1600'(3));

    // 1: all-zero state
    xact(1'b0, '0, '0, 0, "zero");

    // 2: single bit in A[0][0]
    a = '0; a[63:0] = 64'h1;
    e = '0; e[63:0] = 64'h1;
    for (int y = 0; y < 5; y++) begin
      e[(5+y)*64 +: 64]  = 64'h1;
      e[(20+y)*64 +: 64] = 64'h2;
    end
    xact(1'b0, a, e, 0, "a00");

    // 3: MSB of A[1][0] wraps through the rotate
    a = '0; a[5*64 +: 64] = 64'h8000_0000_0000_0000;
    e = '0; e[5*64 +: 64] = 64'h8000_0000_0000_0000;
    for (int y = 0; y < 5; y++) begin
      e[y*64 +: 64]       = 64'h1;
      e[(10+y)*64 +: 64]  = 64'h8000_0000_0000_0000;
    end
    xact(1'b0, a, e, 0, "wrap64");

    // 4: same at LANE_W=8
    a = '0; a[5*8 +: 8] = 8'h80;
    e = '0; e[5*8 +: 8] = 8'h80;
    for (int y = 0; y < 5; y++) begin
      e[y*8 +: 8]      = 8'h01;
      e[(10+y)*8 +: 8] = 8'h80;
    end
    xact(1'b1, a, e, 0, "wrap8");

    // 5: stall in DONE for 10 cycles
    a = rnd_state();
    xact(1'b0, a, theta_model(a, 64), 10, "stall");

    // Random states against the model
    for (int i = 0; i < 6; i++) begin
      a = rnd_state();
      xact(1'b0, a, theta_model(a, 64), i % 3, "rnd64");
    end
    for (int i = 0; i < 4; i++) begin
      a = rnd_state(); a[1599:200] = '0;
      xact(1'b1, a, theta_model(a, 8), i % 2, "rnd8");
    end

    // 6: reset in the third PARITY cycle drops the transaction
    si64 = rnd_state();
    iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("mid_rst_flags", 1600'({ov64, bz64, ir64}), 1600'(0));
    chk("mid_rst_out", so64, '0);
`ifdef KECCAK_THETA_PARITY_OUT_EN
    chk("mid_rst_parity", 1600'(po64), '0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_ready", 1600'(ir64), 1600'(1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov64 || so64 !== '0) bad++;
      @(posedge clk); #1;
    end
    chk("mid_no_valid", 1600'(bad), 1600'(0));

    // Recovers after the dropped transaction
    a = rnd_state();
    xact(1'b0, a, theta_model(a, 64), 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
